traffic_light_button_in: RTL and testbench

//  Avalon-MM slave input port; the read-side counterpart of the HEX output ports.

---
 rtl/traffic_light_button_in_pkg.sv | 27 ++
 rtl/traffic_light_button_in_if.sv | 19 +
 rtl/traffic_light_button_in_debounce.sv | 53 +++++
 rtl/traffic_light_button_in.sv | 83 ++++++++
 tb/tb_traffic_light_button_in.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/traffic_light_button_in_pkg.sv
// Shared definitions for the button/switch input port: register offsets,
// edge-type encodings and the per-bit edge detector.
package traffic_light_pio_pkg;

  typedef enum logic [1:0] {
    ADDR_DATA = 2'd0,
    ADDR_DIR  = 2'd1,
    ADDR_MASK = 2'd2,
    ADDR_EDGE = 2'd3
  } reg_addr_e;

  localparam int unsigned EDGE_RISING  = 0;
  localparam int unsigned EDGE_FALLING = 1;
  localparam int unsigned EDGE_ANY     = 2;

  // Edge events between the current and previous debounced level.
  function automatic logic [31:0] edge_detect(input int unsigned edge_type,
                                              input logic [31:0] cur,
                                              input logic [31:0] prev);
    case (edge_type)
      EDGE_RISING:  return cur & ~prev;
      EDGE_FALLING: return ~cur & prev;
      default:      return cur ^ prev;
    endcase
  endfunction

endpackage

// File: rtl/traffic_light_button_in_if.sv
// Avalon-MM slave bus for the input port, plus its interrupt line.
interface traffic_light_button_in_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq
  );
endinterface

// File: rtl/traffic_light_button_in_debounce.sv
// One input bit: synchroniser chain followed by a stability counter that
// only lets a new level through after it has persisted long enough.
module traffic_light_debounce #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter logic        RESET_VAL       = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic level
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;

  // Shift the raw input through the synchroniser flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= {SYNC_STAGES{RESET_VAL}};
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], din};
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

  if (DEBOUNCE_CYCLES == 0) begin : g_bypass
    // No filtering: level is the synchroniser output, registered once.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) level <= RESET_VAL;
      else          level <= sync_out;
    end
  end else begin : g_filter
    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] cnt;

    // Count consecutive disagreeing cycles; accept the new level on the last one.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cnt   <= '0;
        level <= RESET_VAL;
      end else if (sync_out == level) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        level <= sync_out;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/traffic_light_button_in.sv
// Avalon-MM input port: debounced levels, sticky edge capture with W1C,
// interrupt mask and a registered level interrupt.
module traffic_light_button_in
  import traffic_light_pio_pkg::*;
#(
  parameter int unsigned      WIDTH           = 4,
  parameter int unsigned      SYNC_STAGES     = 2,
  parameter int unsigned      DEBOUNCE_CYCLES = 50000,
  parameter int unsigned      EDGE_TYPE       = 0,
  parameter logic [WIDTH-1:0] IN_RESET_VAL    = '1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  traffic_light_button_in_if.slave  bus,
  input  logic [WIDTH-1:0]          in_port
);

  logic [WIDTH-1:0] level;
  logic [WIDTH-1:0] level_d;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] edge_clr;
  logic             irq_q;
  logic             wr_en;
  logic             unused_wdata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    traffic_light_debounce #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_VAL       (IN_RESET_VAL[i])
    ) u_db (
      .clk     (clk),
      .reset_n (reset_n),
      .din     (in_port[i]),
      .level   (level[i])
    );
  end

  assign wr_en        = bus.chipselect & ~bus.write_n;
  assign edge_det     = WIDTH'(edge_detect(EDGE_TYPE, 32'(level), 32'(level_d)));
  assign unused_wdata = ^bus.writedata;

  // Decode the W1C clear mask for the edge-capture register.
  always_comb begin
    edge_clr = '0;
    if (wr_en && (reg_addr_e'(bus.address) == ADDR_EDGE))
      edge_clr = bus.writedata[WIDTH-1:0];
  end

  // Edge history, capture, mask and interrupt registers; new edges are OR-ed
  // after the clear so a same-cycle event survives the W1C.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level_d      <= IN_RESET_VAL;
      edge_capture <= '0;
      irq_mask     <= '0;
      irq_q        <= 1'b0;
    end else begin
      level_d      <= level;
      edge_capture <= (edge_capture & ~edge_clr) | edge_det;
      irq_q        <= |(edge_capture & irq_mask);
      if (wr_en && (reg_addr_e'(bus.address) == ADDR_MASK))
        irq_mask <= bus.writedata[WIDTH-1:0];
    end
  end

  // Zero-latency read mux, zero-extended to the bus width.
  always_comb begin
    bus.readdata = '0;
    case (reg_addr_e'(bus.address))
      ADDR_DATA: bus.readdata[WIDTH-1:0] = level;
      ADDR_DIR:  bus.readdata = '0;
      ADDR_MASK: bus.readdata[WIDTH-1:0] = irq_mask;
      ADDR_EDGE: bus.readdata[WIDTH-1:0] = edge_capture;
      default:   bus.readdata = '0;
    endcase
  end

  assign bus.irq = irq_q;

endmodule

// File: tb/tb_traffic_light_button_in.sv
// Scoreboard bench for traffic_light_button_in (WIDTH=4, SYNC_STAGES=2,
// DEBOUNCE_CYCLES=4, falling-edge capture, KEY inputs idle high).
module tb_traffic_light_button_in;
  import traffic_light_pio_pkg::*;

  localparam int W    = 4;
  localparam int SYNC = 2;
  localparam int DC   = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] in_port;

  always #5 clk = ~clk;

  traffic_light_button_in_if bus ();

  traffic_light_button_in #(
    .WIDTH           (W),
    .SYNC_STAGES     (SYNC),
    .DEBOUNCE_CYCLES (DC),
    .EDGE_TYPE       (EDGE_FALLING),
    .IN_RESET_VAL    (4'hF)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .in_port (in_port)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  addr;
    logic [31:0] exp;
  } rd_exp_t;

  rd_exp_t sb[$];
  rd_exp_t mon_e;
  logic    rd_active = 1'b0;

  // ---------------- reference model ----------------
  // in_port is seen SYNC edges late; a bit's level flips once the delayed
  // input has disagreed with it for DC consecutive cycles.
  logic [3:0] m_pipe [SYNC];
  logic [3:0] m_level, m_level_d, m_cap, m_mask, m_nlev;
  logic       m_irq;
  int         m_run  [W];
  int         m_nrun [W];

  always_comb begin
    m_nlev = m_level;
    m_nrun = m_run;
    for (int b = 0; b < W; b++) begin
      if (m_pipe[SYNC-1][b] != m_level[b]) begin
        m_nrun[b] = m_run[b] + 1;
        if (m_nrun[b] >= DC) begin
          m_nlev[b] = m_pipe[SYNC-1][b];
          m_nrun[b] = 0;
        end
      end else begin
        m_nrun[b] = 0;
      end
    end
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC; i++) m_pipe[i] <= 4'hF;
      for (int b = 0; b < W; b++) m_run[b] <= 0;
      m_level   <= 4'hF;
      m_level_d <= 4'hF;
      m_cap     <= 4'h0;
      m_mask    <= 4'h0;
      m_irq     <= 1'b0;
    end else begin
      m_pipe[0] <= in_port;
      for (int i = 1; i < SYNC; i++) m_pipe[i] <= m_pipe[i-1];
      m_run     <= m_nrun;
      m_level   <= m_nlev;
      m_level_d <= m_level;
      m_irq     <= |(m_cap & m_mask);
      if (bus.chipselect && !bus.write_n && bus.address == 2'd3)
        m_cap <= (m_cap & ~bus.writedata[3:0]) | (m_level_d & ~m_level);
      else
        m_cap <= m_cap | (m_level_d & ~m_level);
      if (bus.chipselect && !bus.write_n && bus.address == 2'd2)
        m_mask <= bus.writedata[3:0];
    end
  end

  function automatic logic [31:0] model_read(input logic [1:0] a);
    case (a)
      2'd0:    return {28'h0, m_level};
      2'd2:    return {28'h0, m_mask};
      2'd3:    return {28'h0, m_cap};
      default: return 32'h0;
    endcase
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: irq every cycle, and one scoreboard entry per read strobe.
  always begin
    @(negedge clk);
    #2;
    if (reset_n === 1'b1) chk("irq", {31'h0, bus.irq}, {31'h0, m_irq});
    if (rd_active) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow: read with no expected entry at %0t", $time);
      end else begin
        mon_e = sb.pop_front();
        chk($sformatf("read_addr%0d", mon_e.addr), bus.readdata, mon_e.exp);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp);
    rd_exp_t e;
    e.addr = a;
    e.exp  = exp;
    bus.address    = a;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b1;
    rd_active      = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    bus.chipselect = 1'b0;
    rd_active      = 1'b0;
  endtask

  task automatic rd_model(input logic [1:0] a);
    rd(a, model_read(a));
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.address    = a;
    bus.writedata  = d;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    int r;
    reset_n        = 1'b0;
    in_port        = 4'hF;
    bus.address    = 2'd0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = 32'h0;
    tick(3);
    reset_n = 1'b1;
    tick(1);

    // 1: reset values, DIR/DATA writes ignored
    rd(2'd0, 32'hF);
    rd(2'd3, 32'h0);
    rd(2'd2, 32'h0);
    chk("irq_reset", {31'h0, bus.irq}, 32'h0);
    wr(2'd1, 32'hFF);
    rd(2'd1, 32'h0);
    wr(2'd0, 32'h0);
    rd(2'd0, 32'hF);

    // 2: bit0 falls; level at k+5, capture at k+6, masked irq stays low
    in_port[0] = 1'b0;
    tick(4);
    rd(2'd3, 32'h0);
    rd(2'd0, 32'hF);
    rd(2'd0, 32'hE);
    rd(2'd3, 32'h1);
    tick(5);
    chk("irq_masked", {31'h0, bus.irq}, 32'h0);

    // 3: short glitches on bit1 are filtered
    for (int len = 1; len <= 3; len++) begin
      in_port[1] = 1'b0;
      tick(len);
      in_port[1] = 1'b1;
      tick(8);
      rd(2'd0, 32'hE);
      rd(2'd3, 32'h1);
    end

    // 4: unmask pending edge, then clear it
    wr(2'd2, 32'h1);
    chk("irq_mask_lat", {31'h0, bus.irq}, 32'h0);
    tick(1);
    chk("irq_unmask", {31'h0, bus.irq}, 32'h1);
    rd(2'd2, 32'h1);
    wr(2'd3, 32'h1);
    chk("irq_clr_lat", {31'h0, bus.irq}, 32'h1);
    rd(2'd3, 32'h0);
    chk("irq_cleared", {31'h0, bus.irq}, 32'h0);

    // 5: capture of bit2 coincides with a W1C of bit2; set wins
    in_port[2] = 1'b0;
    tick(6);
    wr(2'd3, 32'h4);
    rd(2'd3, 32'h4);
    rd(2'd0, 32'hA);
    wr(2'd3, 32'h4);
    rd(2'd3, 32'h0);

    // 6: reset in the middle of bit3's debounce
    in_port[3] = 1'b0;
    tick(4);
    reset_n = 1'b0;
    in_port = 4'hF;
    tick(2);
    reset_n = 1'b1;
    rd(2'd0, 32'hF);
    rd(2'd3, 32'h0);
    rd(2'd2, 32'h0);
    tick(10);
    rd(2'd0, 32'hF);
    rd(2'd3, 32'h0);
    chk("irq_after_reset", {31'h0, bus.irq}, 32'h0);

    // Random traffic against the model
    for (int it = 0; it < 1500; it++) begin
      if ($urandom_range(0, 5) == 0)
        in_port[$urandom_range(0, 3)] = ~in_port[$urandom_range(0, 3)];
      r = $urandom_range(0, 9);
      if (r <= 4)      rd_model(2'($urandom_range(0, 3)));
      else if (r == 5) wr(2'd2, $urandom);
      else if (r == 6) wr(2'd3, $urandom);
      else if (r == 7) wr(2'($urandom_range(0, 1)), $urandom);
      else             tick(1);
    end
    tick(2);
    chk("sb_empty", 32'(sb.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
